// File: rtl/mem_arbiter.sv
// Two-CPU round-robin arbiter in front of a single memory port, with a
// per-access wait-state timeout that forces an error completion.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] adr0,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          busy0,
    output logic          busy1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          grantSel;

    // Under contention the CPU that did not win last time is served.
    assign grantSel = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grantSel;
                    adr_d   = grantSel ? adr1 : adr0;
                    wdata_d = grantSel ? wdata1 : wdata0;
                    rw_d    = grantSel ? rw1 : rw0;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d = RESP;
                    if (rw_q) rdata_d = mem_rdata;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    tmo_d   = 1'b1;
                    if (rw_q) rdata_d = '1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                last_d  = owner_q;
                tmo_d   = 1'b0;
                rw_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
        end
    end

    // All handshake outputs decode registered state only, so they never glitch.
    assign mem_en    = (state_q == ACCESS);
    assign ack0      = (state_q == RESP) && !owner_q;
    assign ack1      = (state_q == RESP) && owner_q;
    assign err       = (state_q == RESP) && tmo_q;
    assign busy0     = (state_q != IDLE) && owner_q;
    assign busy1     = (state_q != IDLE) && !owner_q;
    assign rdata     = rdata_q;
    assign mem_rw    = rw_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- AW, 16: address width.
- DW, 16: data width.
- TIMEOUT, 15: maximum ACCESS cycles to wait for mem_ready.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req0 / req1, in, 1: access request from CPU 0 / CPU 1; held until that CPU's ack.
- rw0 / rw1, in, 1: 1 = read, 0 = write.
- adr0 / adr1, in, AW: request address.
- wdata0 / wdata1, in, DW: write data.
- ack0 / ack1, out, 1: one-cycle completion pulse to the owner.
- busy0 / busy1, out, 1: high while the other CPU owns the bus.
- err, out, 1: timeout flag; pulses together with the ack.
- rdata, out, DW: read data returned to the owner, valid during ack.
- mem_en, out, 1: memory access strobe.
- mem_rw, out, 1: 1 = read, 0 = write.
- mem_adr, out, AW: memory address.
- mem_wdata, out, DW: memory write data.
- mem_rdata, in, DW: memory read data.
- mem_ready, in, 1: memory completion indication, sampled only in ACCESS.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, ACCESS and RESP, and SHALL hold an owner bit and a last-granted bit.
REQ-004 IDLE, single request: on the edge where exactly one req is high, that requester SHALL become owner and the FSM SHALL go to ACCESS.
REQ-005 IDLE, both requests high: the requester that is NOT last-granted SHALL become owner (round-robin).
REQ-006 On the grant edge, the owner's adr, wdata and rw SHALL be registered into mem_adr, mem_wdata and mem_rw; these SHALL stay stable until the FSM returns to IDLE.
REQ-007 In ACCESS, mem_en SHALL be 1, and a wait counter SHALL count from 0, incrementing by 1 per ACCESS cycle.
REQ-008 ACCESS completion:
- mem_ready high on an edge in ACCESS -> go to RESP.
- If the access is a read, mem_rdata SHALL be captured into rdata on that edge.
REQ-009 ACCESS timeout: if the counter reaches TIMEOUT-1 with mem_ready low -> go to RESP with a timeout flag set; a timed-out read SHALL return rdata = all ones.
REQ-010 A timed-out write SHALL leave rdata unchanged.
REQ-011 In RESP:
- ack of the owner SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
- err SHALL be 1 only if a timeout occurred.
REQ-012 On leaving RESP: last-granted SHALL be set to owner, the timeout flag SHALL clear, and the FSM SHALL go to IDLE.
REQ-013 mem_en SHALL be 0 outside ACCESS; mem_rw SHALL be 1 while in IDLE.
REQ-014 Latency: with req sampled on edge E0 and mem_ready high on E1, ack SHALL be high in the cycle after E1.
- Minimum grant-to-ack latency is 2 cycles.
- Each transaction occupies at least 3 cycles (IDLE, ACCESS, RESP).
REQ-015 busyN SHALL be 1 exactly when state != IDLE and owner != N, decoded from registered state only (glitch-free).
REQ-016 A req deasserted during ACCESS SHALL NOT abort the access; the access completes and ack is still issued.
REQ-017 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-018 mem_ready high outside ACCESS SHALL be ignored.
REQ-019 The wait counter SHALL be clog2(TIMEOUT)+1 bits wide and SHALL never wrap within an access.

Reset
REQ-020 reset low SHALL immediately, asynchronously to clk, force the following values:
- state = IDLE, owner = 0, last-granted = 1, wait counter = 0.
- ack0, ack1, busy0, busy1, err, mem_en = 0.
- mem_rw = 1; rdata, mem_adr, mem_wdata = 0.
REQ-021 reset asserted mid-ACCESS SHALL abort the access with no ack; the first request after reset release SHALL be from CPU 0 if both are pending.

Verification
REQ-022 Single read:
- Stimulus: req0=1, rw0=1, adr0=16'h0012; mem_ready high in the first ACCESS cycle with mem_rdata=16'h00A5.
- Response: mem_adr=16'h0012, mem_en=1 for 1 cycle; ack0 pulse with rdata=16'h00A5; err=0; busy1=1 during ACCESS and RESP.
REQ-023 Simultaneous requests after reset:
- Stimulus: req0=req1=1.
- Response: CPU 0 is served first; busy1=1 while CPU 0 owns the bus. CPU 1 is granted on the edge after CPU 0's RESP (req0 dropped), with no idle gap beyond the one IDLE cycle.
REQ-024 Round-robin under contention:
- Stimulus: both reqs held high continuously for 4 transactions.
- Response: grant order is 0, 1, 0, 1.
REQ-025 Write with wait states:
- Stimulus: req1=1, rw1=0, adr1=16'h0040, wdata1=16'h0077; mem_ready delayed 5 cycles.
- Response: mem_en=1 for 6 cycles; mem_wdata stays 16'h0077 throughout; ack1 pulse; rdata unchanged.
REQ-026 Read timeout:
- Stimulus: read request with mem_ready held low.
- Response: after 15 ACCESS cycles, ack and err pulse together with rdata=16'hFFFF; the next request proceeds normally.
REQ-027 Reset mid-access:
- Stimulus: reset low during ACCESS of CPU 1.
- Response: all outputs go to reset values immediately; no ack1 is ever issued; on release with both reqs pending, CPU 0 is granted.
